uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one UART transmitter (the `UART_Tx` counterpart of the receiver) among `NUM_REQ` on-chip requesters, such as the time display, debug echo and sensor logger. It accepts one byte at a time from the winning requester and launches it with a single-cycle data-valid pulse. It waits for the transmitter's done pulse before arbitrating again. Optionally it locks the grant for a multi-byte packet.

---
 rtl/uart_tx_arbiter_if.sv | 9 +
 rtl/uart_tx_arbiter.sv | 82 ++++++++
 tb/tb_uart_tx_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals for uart_tx_arbiter
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req, last, ack, grant;
  logic [8*NUM_REQ-1:0] data;
  logic busy, tx_dv, tx_active, tx_done;
  logic [7:0] tx_byte;
  modport master (input req, data, last, tx_active, tx_done, output ack, grant, busy, tx_dv, tx_byte);
  modport slave (output req, data, last, tx_active, tx_done, input ack, grant, busy, tx_dv, tx_byte);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; define UART_TX_ARB_LOCK_EN to lock the grant per packet
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
`ifdef UART_TX_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
  logic [CW-1:0] cnt;
  logic last_q;
`else
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
`endif
  state_t state, state_n;
  logic [IW-1:0] owner, owner_n, ptr, win, k;
  logic [NUM_REQ-1:0] grant;
  if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_TIMEOUT < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and LOCK_TIMEOUT >= 1");
  end
  // descending scan so the requester closest after ptr is assigned last and wins
  always_comb begin
    win = ptr;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (bus.req[k]) win = k;
    end
  end
  always_comb begin
    state_n = state;
    owner_n = owner;
    case (state)
      IDLE: if (|bus.req && !bus.tx_active) begin
        state_n = LAUNCH;
        owner_n = win;
      end
      LAUNCH: state_n = WAIT;
`ifdef UART_TX_ARB_LOCK_EN
      WAIT: if (bus.tx_done) state_n = last_q ? IDLE : (bus.req[owner] ? LAUNCH : HOLD);
      HOLD: state_n = bus.req[owner] ? LAUNCH : (cnt == CW'(LOCK_TIMEOUT - 1) ? IDLE : HOLD);
`else
      WAIT: if (bus.tx_done) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      ptr <= IW'(NUM_REQ - 1);
      grant <= '0;
      bus.tx_byte <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      grant <= state_n == IDLE ? '0 : NUM_REQ'(1) << owner_n;
      if (state == LAUNCH) ptr <= owner;
      if (state_n == LAUNCH) bus.tx_byte <= bus.data[{owner_n, 3'b000} +: 8];
    end
  end
`ifdef UART_TX_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      last_q <= 1'b0;
    end else begin
      cnt <= state == HOLD ? cnt + CW'(1) : '0;
      if (state_n == LAUNCH) last_q <= bus.last[owner_n];
    end
  end
`endif
  assign bus.tx_dv = state == LAUNCH;
  assign bus.ack = state == LAUNCH ? grant : '0;
  assign bus.grant = grant;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a queue-based scoreboard checked at every launch
module tb_uart_tx_arbiter;
  localparam int FRAME = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0, mismatched = 0, dv_cnt = 0, tx_cnt = 0;
  logic prev_dv = 1'b0;
  logic [8:0] mem [4][16];
  logic [3:0] head [4], tail [4];
  logic [11:0] exp_q [$];
  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();
  uart_tx_arbiter #(.NUM_REQ(4), .LOCK_TIMEOUT(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input int r, input logic [7:0] b, input logic l);
    mem[r][tail[r]] = {l, b};
    tail[r] = tail[r] + 4'd1;
  endtask
  task automatic expect_tx(input int r, input logic [7:0] b);
    exp_q.push_back({4'(r), b});
  endtask
  task automatic wait_idle();
    int n = 0;
    while (n < 2000 && !(head == tail && !bus.busy && !bus.tx_active)) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'(n), 32'd0);
  endtask
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  // requesters: present the head byte, advance on ack
  initial begin
    for (int i = 0; i < 4; i++) begin head[i] = '0; tail[i] = '0; end
    bus.req = '0; bus.data = '0; bus.last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) head[i] = head[i] + 4'd1;
        bus.req[i] = head[i] != tail[i];
        bus.data[8*i +: 8] = mem[i][head[i]][7:0];
        bus.last[i] = mem[i][head[i]][8];
      end
    end
  end
  // transmitter: busy for FRAME cycles after each launch, then a done pulse
  initial begin
    bus.tx_active = 1'b0; bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin bus.tx_active = 1'b0; bus.tx_done = 1'b1; end
      end else if (bus.tx_dv) begin
        bus.tx_active = 1'b1;
        tx_cnt = FRAME;
      end
    end
  end
  always @(negedge clk) begin
    if (bus.tx_dv) begin
      logic [11:0] e;
      dv_cnt++;
      check("dv_width", 32'(prev_dv), 32'd0);
      if (exp_q.size() == 0) check("unexpected_launch", 32'(bus.grant), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("ack", 32'(bus.ack), 32'(4'b0001 << e[11:8]));
        check("grant", 32'(bus.grant), 32'(4'b0001 << e[11:8]));
        check("tx_byte", 32'(bus.tx_byte), 32'(e[7:0]));
      end
    end
    prev_dv = bus.tx_dv;
  end
  initial begin
    int n, dv0;
    for (int i = 0; i < 4; i++) push(i, 8'hC0 + 8'(i), 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_tx_dv", 32'(bus.tx_dv), 0);
    check("rst_tx_byte", 32'(bus.tx_byte), 0);
    for (int i = 0; i < 4; i++) expect_tx(i, 8'hC0 + 8'(i));
    rst_n = 1'b1;
    wait_idle();
    push(2, 8'hA5, 1'b1);
    expect_tx(2, 8'hA5);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.req[2] && n < 50);
    @(negedge clk); #1;
    check("launch_latency", 32'(bus.tx_dv), 1);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.tx_done && n < 50);
    check("busy_at_done", 32'(bus.busy), 1);
    @(negedge clk); #1;
    check("busy_after_done", 32'(bus.busy), 0);
    wait_idle();
    do_reset();
    push(0, 8'h01, 1'b1); push(1, 8'h02, 1'b1); push(3, 8'h03, 1'b1);
    push(0, 8'h04, 1'b1); push(1, 8'h05, 1'b1); push(3, 8'h06, 1'b1);
    expect_tx(0, 8'h01); expect_tx(1, 8'h02); expect_tx(3, 8'h03);
    expect_tx(0, 8'h04); expect_tx(1, 8'h05); expect_tx(3, 8'h06);
    wait_idle();
    push(0, 8'h20, 1'b1);
    expect_tx(0, 8'h20);
    wait_idle();
    push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1); push(0, 8'h21, 1'b1);
    expect_tx(1, 8'h10);
`ifdef UART_TX_ARB_LOCK_EN
    expect_tx(1, 8'h11); expect_tx(0, 8'h21);
`else
    expect_tx(0, 8'h21); expect_tx(1, 8'h11);
`endif
    wait_idle();
    do_reset();
    push(1, 8'h30, 1'b0); push(2, 8'h40, 1'b1);
    expect_tx(1, 8'h30); expect_tx(2, 8'h40);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.tx_done && n < 50);
`ifdef UART_TX_ARB_LOCK_EN
    repeat (10) @(negedge clk);
    #1;
    check("hold_grant", 32'(bus.grant), 32'b0010);
    @(negedge clk); #1;
    check("timeout_clear", 32'(bus.grant), 0);
`else
    @(negedge clk); #1;
    check("unlocked_release", 32'(bus.grant), 0);
`endif
    wait_idle();
    push(3, 8'h55, 1'b1);
    expect_tx(3, 8'h55);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!bus.tx_active && n < 50);
    @(negedge clk); #1;
    rst_n = 1'b0;
    push(0, 8'h66, 1'b1);
    expect_tx(0, 8'h66);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    dv0 = dv_cnt;
    n = 0;
    while (bus.tx_active && n < 50) begin @(negedge clk); #1; n++; end
    check("no_dv_during_frame", 32'(dv_cnt), 32'(dv0));
    wait_idle();
    check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
